four_bit_div: RTL
=================

# four_bit_div

Sequential 8-by-4 unsigned restoring divider for the 4-bit ALU. It is the inverse of the ALU's 4-bit multiply path: it splits an 8-bit dividend by a 4-bit divisor into a 4-bit quotient and a 4-bit remainder. It uses one subtract/shift step per cycle behind a start/done handshake. Divide-by-zero and quotient overflow are flagged, not computed.

## Interface
- No parameters; widths are fixed at 8-bit dividend and 4-bit divisor/quotient/remainder.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  8  unsigned; sampled with accepted start
- divisor  in  4  unsigned; sampled with accepted start
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse; results valid from this cycle on
- quotient  out  4  registered result
- remainder  out  4  registered result
- div_by_zero  out  1  divisor was 0 for the last completed operation
- overflow  out  1  dividend[7:4] >= divisor (nonzero) for the last completed operation

## Operation
- States are IDLE, CALC, DONE. Reset enters IDLE.
- IDLE with start=1 (all cases latch operands):
  - divisor==0 → DONE. Result: div_by_zero=1, overflow=0, quotient=4'hF, remainder=4'h0.
  - else dividend[7:4] >= divisor → DONE. Result: overflow=1, div_by_zero=0, quotient=4'hF, remainder=4'h0.
  - else → CALC. Internal regs: R(4)=dividend[7:4], Q(4)=dividend[3:0], step counter=0.
- CALC, once per cycle, 4 cycles total:
  - T(5) = {R, Q[3]}; D = T − {1'b0, divisor}.
  - If D is non-negative: R=D[3:0], Q={Q[2:0],1}. Else: R=T[3:0], Q={Q[2:0],0}.
  - After the 4th step, go to DONE.
  - R < divisor holds before every step, so T < 2·divisor and the new R fits in 4 bits.
- DONE (entered from CALC): quotient=Q, remainder=R, both flags=0.
- DONE lasts one cycle with done=1, then returns to IDLE.
- Flag priority: div_by_zero over overflow.
- Arithmetic: fully unsigned. For non-error results, quotient·divisor + remainder == dividend and remainder < divisor.
- start in CALC or DONE is ignored. Operands are not re-sampled. No queuing.
- Input changes after acceptance do not affect the operation in progress.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state=IDLE, counter=0.
- Let edge E be the edge that accepts start.
- Normal divide:
  - busy=1 in the 4 cycles after E.
  - done=1 in the 5th cycle after E.
  - Latency is 5 cycles.
- Error divide: done=1 in the cycle immediately after E. busy stays 0. Latency is 1 cycle.
- Result outputs and flags update on the edge that enters DONE. They hold until the next operation's DONE entry or reset, and are not cleared at start.
- done and busy are never high together.
- Maximum throughput is one start per 6 cycles. The next start is accepted in IDLE, the cycle after done.
- rst=1 on any edge, including mid-CALC or in DONE:
  - Aborts the operation and forces all reset values.
  - No done pulse is issued for the aborted operation.
  - start on the same edge as rst is ignored.

## Test plan
- dividend=8'd100, divisor=4'd7, start for 1 cycle → busy high 4 cycles, then done pulse at E+5 with quotient=4'd14, remainder=4'd2, both flags 0.
- dividend=8'd225, divisor=4'd15 → quotient=4'd15, remainder=4'd0, no flags. dividend=8'd0, divisor=4'd1 → quotient=0, remainder=0.
- divisor=4'd0, dividend=8'd55 → done at E+1, div_by_zero=1, overflow=0, quotient=4'hF, remainder=0, busy never high. divisor=4'd8, dividend=8'h80 → overflow=1, same latency and values.
- Mid-operation behaviour:
  - start=1 held continuously, operands changed during CALC → only the first operands are used.
  - The next operation is accepted at the IDLE cycle after done; one done per accepted start.
  - Assert rst at E+2 → all outputs return to 0 next edge, no done pulse; a following start divides correctly.
- Exhaustive sweep of all 256×16 operand pairs, back-to-back, against a reference model:
  - Non-error results must match the model and satisfy quotient·divisor+remainder==dividend.
  - Error cases must match the flag rules above.

Source files
------------

// File: rtl/four_bit_div.sv
// Sequential 8-by-4 unsigned restoring divider: one subtract/shift step per cycle
// behind a start/done handshake. Divide-by-zero and quotient overflow are flagged.
module four_bit_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [3:0] q_q, q_d;
  logic [3:0] dvs_q, dvs_d;
  logic [1:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;
  logic [4:0] trial;
  logic [4:0] diff;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    // R < divisor before each step, so diff[4] alone tells whether T >= divisor
    trial   = {r_q, q_q[3]};
    diff    = trial - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = divisor;
          r_d   = dividend[7:4];
          q_d   = dividend[3:0];
          cnt_d = 2'd0;
          if (divisor == 4'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = 4'hF;
            rem_d   = 4'h0;
          end else if (dividend[7:4] >= divisor) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            quot_d  = 4'hF;
            rem_d   = 4'h0;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        if (!diff[4]) begin
          r_d = diff[3:0];
          q_d = {q_q[2:0], 1'b1};
        end else begin
          r_d = trial[3:0];
          q_d = {q_q[2:0], 1'b0};
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      q_q     <= 4'd0;
      dvs_q   <= 4'd0;
      cnt_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
